// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_decoder
// Brief    : PS/2 keyboard receiver with glitch filter, frame checking, receive
//            timeout and set-2 make/break decoding into an 8-bit held-key vector.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_key_decoder #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       iPS2_CLK,
  input  logic       iPS2_DAT,
  output logic [7:0] oKey,
  output logic [7:0] oCode,
  output logic       oCode_valid,
  output logic       oFrame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0] C_FLT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] C_TO_LAST  = TW'(TIMEOUT - 1);

  localparam logic [7:0] C_EXT = 8'hE0;
  localparam logic [7:0] C_BRK = 8'hF0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // Synchronisers preset high so a released line never looks like an edge.
  logic r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= iPS2_CLK;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= iPS2_DAT;
      r_dat_s2 <= r_dat_s1;
    end
  end

  logic [FW-1:0] r_flt_cnt;
  logic          r_clk_f;
  logic          r_clk_f_d;
  logic          w_fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_flt_cnt <= '0;
      r_clk_f   <= 1'b1;
      r_clk_f_d <= 1'b1;
    end else begin
      r_clk_f_d <= r_clk_f;
      if (r_clk_s2 != r_clk_f) begin
        if (r_flt_cnt == C_FLT_LAST) begin
          r_clk_f   <= r_clk_s2;
          r_flt_cnt <= '0;
        end else begin
          r_flt_cnt <= r_flt_cnt + 1'b1;
        end
      end else begin
        r_flt_cnt <= '0;
      end
    end
  end

  assign w_fall = r_clk_f_d & ~r_clk_f;

  state_t        r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic [TW-1:0] r_to_cnt;
  logic [7:0]    r_code;
  logic          r_valid;
  logic          r_err;
  logic          w_par_ok;

  assign w_par_ok = ^{r_shift, r_parity};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_to_cnt  <= '0;
      r_code    <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (w_fall) begin
        // An edge coinciding with the terminal count is still processed.
        r_to_cnt <= '0;
        case (r_state)
          S_IDLE: begin
            if (!r_dat_s2) begin
              r_state   <= S_DATA;
              r_bit_cnt <= '0;
              r_shift   <= '0;
            end
          end
          S_DATA: begin
            r_shift   <= {r_dat_s2, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == 3'd7) begin
              r_state <= S_PARITY;
            end
          end
          S_PARITY: begin
            r_parity <= r_dat_s2;
            r_state  <= S_STOP;
          end
          S_STOP: begin
            r_state <= S_IDLE;
            if (w_par_ok && r_dat_s2) begin
              r_code  <= r_shift;
              r_valid <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end else if (r_state == S_IDLE) begin
        r_to_cnt <= '0;
      end else if (r_to_cnt == C_TO_LAST) begin
        r_state  <= S_IDLE;
        r_err    <= 1'b1;
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  logic       r_ext;
  logic       r_brk;
  logic [7:0] r_key;
  logic       w_map_hit;
  logic [2:0] w_map_idx;

  // Arrows only match behind an E0 prefix; WASD only without one.
  always_comb begin
    w_map_hit = 1'b0;
    w_map_idx = 3'd0;
    if (r_ext) begin
      case (r_code)
        8'h74: begin w_map_hit = 1'b1; w_map_idx = 3'd0; end
        8'h6B: begin w_map_hit = 1'b1; w_map_idx = 3'd1; end
        8'h72: begin w_map_hit = 1'b1; w_map_idx = 3'd2; end
        8'h75: begin w_map_hit = 1'b1; w_map_idx = 3'd3; end
        default: ;
      endcase
    end else begin
      case (r_code)
        8'h23: begin w_map_hit = 1'b1; w_map_idx = 3'd4; end
        8'h1C: begin w_map_hit = 1'b1; w_map_idx = 3'd5; end
        8'h1B: begin w_map_hit = 1'b1; w_map_idx = 3'd6; end
        8'h1D: begin w_map_hit = 1'b1; w_map_idx = 3'd7; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
      r_key <= '0;
    end else if (r_valid) begin
      if (r_code == C_EXT) begin
        r_ext <= 1'b1;
      end else if (r_code == C_BRK) begin
        r_brk <= 1'b1;
      end else begin
        if (w_map_hit) begin
          r_key[w_map_idx] <= ~r_brk;
        end
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end
    end
  end

  assign oKey        = r_key;
  assign oCode       = r_code;
  assign oCode_valid = r_valid;
  assign oFrame_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_key_decoder
// Brief    : Table-driven, scoreboarded bench for ps2_key_decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_key_decoder;

  localparam int FLT  = 8;
  localparam int TOUT = 600;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] key, code;
  logic       code_valid, frame_err;

  ps2_key_decoder #(.FILTER_LEN(FLT), .TIMEOUT(TOUT)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .iPS2_CLK    (ps2_clk),
    .iPS2_DAT    (ps2_dat),
    .oKey        (key),
    .oCode       (code),
    .oCode_valid (code_valid),
    .oFrame_err  (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    int         bad;   // 0 good, 1 parity wrong, 2 stop bit low
    logic [7:0] key;
  } vec_t;

  typedef struct {
    logic       is_err;
    logic [7:0] code;
    logic [7:0] key;
  } exp_t;

  int         checks = 0;
  int         failures = 0;
  exp_t       q[$];
  logic       key_pend = 1'b0;
  logic [7:0] pend_key;
  logic [7:0] last_code = 8'h00;
  vec_t       vecs[17];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every output event is matched against the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      if (key_pend) begin
        check("key_after_event", key, pend_key);
        key_pend = 1'b0;
      end
      if (code_valid || frame_err) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event: valid=%b err=%b code=%h", code_valid, frame_err, code);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("event_kind", {6'd0, code_valid, frame_err}, {6'd0, ~e.is_err, e.is_err});
          check("ocode", code, e.code);
          key_pend = 1'b1;
          pend_key = e.key;
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    wait_cycles(HALF);
    ps2_clk = 1'b0;
    wait_cycles(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] c, input int bad, input logic [7:0] exp_key);
    logic [10:0] bits;
    exp_t e;
    logic par;
    par = ~^c;
    if (bad == 1) par = ~par;
    bits = {(bad == 2) ? 1'b0 : 1'b1, par, c, 1'b0};
    e.is_err = (bad != 0);
    if (bad == 0) last_code = c;
    e.code = last_code;
    e.key  = exp_key;
    q.push_back(e);
    for (int i = 0; i < 11; i++) ps2_bit(bits[i]);
    ps2_dat = 1'b1;
    wait_cycles(12);
  endtask

  initial begin
    int n;
    logic seen;
    logic [7:0] tbits;

    vecs[0]  = '{8'h1D, 0, 8'h80};  // press W
    vecs[1]  = '{8'hF0, 0, 8'h80};
    vecs[2]  = '{8'h1D, 0, 8'h00};  // release W
    vecs[3]  = '{8'hE0, 0, 8'h00};
    vecs[4]  = '{8'h74, 0, 8'h01};  // press right arrow
    vecs[5]  = '{8'hE0, 0, 8'h01};
    vecs[6]  = '{8'hF0, 0, 8'h01};
    vecs[7]  = '{8'h74, 0, 8'h00};  // release right arrow
    vecs[8]  = '{8'h74, 0, 8'h00};  // bare 74 is unmapped
    vecs[9]  = '{8'hE0, 0, 8'h00};
    vecs[10] = '{8'h1D, 0, 8'h00};  // E0 1D is unmapped
    vecs[11] = '{8'h1D, 1, 8'h00};  // parity error
    vecs[12] = '{8'h23, 0, 8'h10};  // press D
    vecs[13] = '{8'h23, 0, 8'h10};  // typematic repeat
    vecs[14] = '{8'hE0, 0, 8'h10};
    vecs[15] = '{8'h75, 0, 8'h18};  // up arrow held alongside D
    vecs[16] = '{8'h6B, 2, 8'h18};  // stop-bit error

    wait_cycles(3);
    check("reset_key", key, 8'h00);
    check("reset_code", code, 8'h00);
    check("reset_flags", {6'd0, code_valid, frame_err}, 8'h00);
    reset_n = 1'b1;
    wait_cycles(5);

    for (int i = 0; i < 17; i++) send_frame(vecs[i].code, vecs[i].bad, vecs[i].key);

    // Timeout: start + 3 data bits, then the clock stays high.
    begin
      exp_t e;
      e.is_err = 1'b1;
      e.code   = last_code;
      e.key    = 8'h18;
      q.push_back(e);
    end
    tbits = 8'h1C;
    ps2_bit(1'b0);
    ps2_bit(tbits[0]);
    ps2_bit(tbits[1]);
    ps2_dat = tbits[2];
    wait_cycles(HALF);
    ps2_clk = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < TOUT + 200) begin
      @(negedge clk);
      n++;
      if (n == HALF) ps2_clk = 1'b1;
      if (frame_err) seen = 1'b1;
    end
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    checks++;
    if (!seen || n != TOUT + FLT + 3) begin
      failures++;
      $display("FAIL timeout_latency: seen=%b cycles=%0d expected %0d", seen, n, TOUT + FLT + 3);
    end
    wait_cycles(5);
    send_frame(8'h1C, 0, 8'h38);

    // Short clock glitch with the line idle: must produce nothing.
    ps2_clk = 1'b0;
    wait_cycles(3);
    ps2_clk = 1'b1;
    wait_cycles(60);
    check("glitch_key", key, 8'h38);
    check("glitch_code", code, 8'h1C);

    // Reset part way through a frame.
    tbits = 8'h23;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(tbits[i]);
    reset_n = 1'b0;
    #1;
    check("midreset_key", key, 8'h00);
    check("midreset_code", code, 8'h00);
    check("midreset_flags", {6'd0, code_valid, frame_err}, 8'h00);
    ps2_dat = 1'b1;
    wait_cycles(5);
    reset_n = 1'b1;
    last_code = 8'h00;
    wait_cycles(5);
    send_frame(8'h1B, 0, 8'h40);
    wait_cycles(10);

    check("scoreboard_empty", 8'(q.size()), 8'h00);
    check("final_key", key, 8'h40);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule
`default_nettype wire
